// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request master for a memory on a shared tri-state data bus.
// One request at a time: write (WRITE -> RESP) or read (READ -> RWAIT x (RD_LAT-1) -> RESP).
// Optional feature macro: WRITE_VERIFY_EN. When defined, every write is followed by a
// read-back of the same address and rsp_err flags a read-back mismatch.
module mem_bus_master #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    inout  wire  [DATA_W-1:0] data_bus
);

    localparam int unsigned CNT_W = 3;
    // Value of r_cnt in the final RWAIT cycle (unused when RD_LAT == 1).
    localparam logic [CNT_W-1:0] RWAIT_LAST = CNT_W'(RD_LAT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_mem_re;
    logic                r_mem_we;
    logic                r_drive;
    logic                w_accept;
    logic                w_rd_last;
`ifdef WRITE_VERIFY_EN
    logic                r_write;
    logic                r_rsp_err;
`endif

    assign w_accept = req_valid & r_ready;

    // Next-state decode; also flags the edge that ends the last read cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
`ifdef WRITE_VERIFY_EN
                w_state_nxt = S_READ;
`else
                w_state_nxt = S_RESP;
`endif
            end
            S_READ: begin
                if (RD_LAT <= 1) begin
                    w_state_nxt = S_RESP;
                    w_rd_last   = 1'b1;
                end else begin
                    w_state_nxt = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (r_cnt == RWAIT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_rd_last   = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, request capture and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_drive     <= 1'b0;
`ifdef WRITE_VERIFY_EN
            r_write     <= 1'b0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (r_state == S_RWAIT) ? r_cnt + CNT_W'(1) : '0;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_mem_re    <= (w_state_nxt == S_READ) || (w_state_nxt == S_RWAIT);
            r_mem_we    <= (w_state_nxt == S_WRITE);
            r_drive     <= (w_state_nxt == S_WRITE);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
`ifdef WRITE_VERIFY_EN
                r_write <= req_write;
`endif
            end
            if (w_rd_last) begin
                r_rsp_rdata <= data_bus;
`ifdef WRITE_VERIFY_EN
                r_rsp_err   <= r_write && (data_bus != r_wdata);
`endif
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_addr  = r_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign data_bus  = r_drive ? r_wdata : {DATA_W{1'bz}};
`ifdef WRITE_VERIFY_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: memory model on a pulled-up bus, scoreboard of expected
// responses, per-cycle bus/handshake monitor.
module tb_mem_bus_master;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 1;
`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Memory model: bit0 stuck at 0 when the write-verify feature is built in.
    localparam logic [DATA_W-1:0] STUCK = VERIFY ? 8'hFE : 8'hFF;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    wire  [DATA_W-1:0] data_bus;

    mem_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .data_bus(data_bus)
    );

    // Undriven bus reads as all ones.
    for (genvar g = 0; g < DATA_W; g++) begin : g_pu
        pullup (data_bus[g]);
    end

    logic [DATA_W-1:0] mem [16];
    assign data_bus = mem_re ? mem[mem_addr] : {DATA_W{1'bz}};
    always @(posedge clk) if (mem_we) mem[mem_addr] <= data_bus & STUCK;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                cyc;
        string             tag;
    } exp_t;

    exp_t              q[$];
    exp_t              mon_e;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                re_cnt = 0;
    int                we_cnt = 0;
    bit                mon_en = 1'b0;
    logic [DATA_W-1:0] ref_mem [16];
    logic [DATA_W-1:0] exp_last;
    logic [DATA_W-1:0] cur_wdata;
    logic [ADDR_W-1:0] cur_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive a request and wait for acceptance; req_valid stays high on return.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit expect_rsp, input string tag, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        cur_addr  = a;
        cur_wdata = d;
        e.tag     = tag;
        if (w) begin
            ref_mem[a] = d & STUCK;
            if (VERIFY) begin
                e.rdata = d & STUCK;
                e.err   = ((d & STUCK) != d);
                e.cyc   = acc + 1 + int'(RD_LAT);
            end else begin
                e.rdata = exp_last;
                e.err   = 1'b0;
                e.cyc   = acc + 1;
            end
        end else begin
            e.rdata = ref_mem[a];
            e.err   = 1'b0;
            e.cyc   = acc + int'(RD_LAT);
        end
        if (expect_rsp) begin
            exp_last = e.rdata;
            q.push_back(e);
        end
    endtask

    // Drop valid and scramble the request fields; the DUT must ignore them.
    task automatic idle_inputs();
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~req_write;
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_drain"}, q.size(), 0);
    endtask

    // Per-cycle monitor: bus ownership, address, handshake and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_re) re_cnt++;
            if (mem_we) we_cnt++;
            chk("we_re_excl", 32'(mem_we & mem_re), 0);
            if (mem_we) begin
                chk("wr_bus", data_bus, cur_wdata);
                chk("wr_addr", mem_addr, cur_addr);
            end else if (mem_re) begin
                chk("rd_addr", mem_addr, cur_addr);
            end else begin
                chk("bus_idle_z", data_bus, 8'hFF);
            end
            if (mem_re || mem_we || rsp_valid) chk("ready_busy", req_ready, 0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.rdata);
                    chk({mon_e.tag, "_err"}, rsp_err, mon_e.err);
                    chk({mon_e.tag, "_latency"}, cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int re0;
        int we0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        exp_last  = '0;
        cur_wdata = '0;
        cur_addr  = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bus_z", data_bus, 8'hFF);
        mon_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst_ready_rise", req_ready, 1);

        // Write then read back the same address
        issue(1'b1, 4'd2, 8'hB5, 1'b1, "wr2", acc);
        idle_inputs();
        issue(1'b0, 4'd2, 8'h00, 1'b1, "rd2", acc);
        idle_inputs();
        drain("t1");

        // Read of untouched location; enable pulse widths
        re0 = re_cnt;
        we0 = we_cnt;
        issue(1'b0, 4'd8, 8'h00, 1'b1, "rd8", acc);
        idle_inputs();
        drain("t2");
        chk("rd8_re_cycles", re_cnt - re0, RD_LAT);
        chk("rd8_we_cycles", we_cnt - we0, 0);

        // Back-to-back reads with req_valid held high
        issue(1'b1, 4'd1, 8'h11, 1'b1, "wr1", acc);
        idle_inputs();
        issue(1'b1, 4'd3, 8'h33, 1'b1, "wr3", acc);
        idle_inputs();
        drain("t3a");
        issue(1'b0, 4'd1, 8'h00, 1'b1, "rd1", acc);
        issue(1'b0, 4'd3, 8'h00, 1'b1, "rd3", acc2);
        idle_inputs();
        chk("b2b_accept_gap", acc2 - acc, 2 + RD_LAT);
        drain("t3b");

        // Reset during the READ cycle abandons the read
        issue(1'b0, 4'd3, 8'h00, 1'b0, "rd_abort", acc);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("abort_mem_re", mem_re, 0);
        chk("abort_bus_z", data_bus, 8'hFF);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_ready_in_rst", req_ready, 0);
        chk("abort_rdata_cleared", rsp_rdata, 0);
        rst      = 1'b0;
        exp_last = '0;
        @(negedge clk);
        chk("abort_ready_after", req_ready, 1);
        repeat (4) @(negedge clk);
        issue(1'b0, 4'd3, 8'h00, 1'b1, "rd3_post", acc);
        idle_inputs();
        drain("t4");

        // Write 0x03 to addr 5 (read-back mismatch when verify is built in), then read it
        issue(1'b1, 4'd5, 8'h03, 1'b1, "wr5", acc);
        idle_inputs();
        issue(1'b0, 4'd5, 8'h00, 1'b1, "rd5", acc);
        idle_inputs();
        drain("t5");

        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
